// File: rtl/mult_div_unit_pkg.sv
// Shared types and helpers for the multiply/divide unit.
package mult_div_unit_pkg;

  // Architectural word width; default for the unit's WIDTH parameter.
  localparam int unsigned WORD_WIDTH = 32;

  // Widest operand the negate helper supports.
  localparam int unsigned MAX_WIDTH = 64;

  // Negate helper width: covers a full double-width product.
  localparam int unsigned NEG_W = 2 * MAX_WIDTH;

  // Decoder classification of HI/LO-affecting instructions.
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_code_e;

  // Two's-complement negate when flag is set; callers zero-extend and truncate.
  function automatic logic [NEG_W-1:0] negate_if(input logic flag,
                                                 input logic [NEG_W-1:0] value);
    return flag ? (~value + NEG_W'(1)) : value;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply,
// restoring divide, one sign-fix/commit cycle after WIDTH iterations.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  mdu_state_e state, state_nxt;
  mdu_code_e  op_code;

  // Iteration datapath: acc holds {partial sum/remainder, multiplier/quotient}.
  logic [ACC_W-1:0] acc;
  logic [WIDTH-1:0] breg;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;

  // Control strobes from the FSM.
  logic accept;
  logic launch;
  logic mt_hi;
  logic mt_lo;
  logic step;
  logic commit;
  logic last_iter;

  // Launch-side operand conditioning.
  logic             op_is_arith;
  logic             op_is_div;
  logic             op_signed;
  logic             use_sign;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // One radix-2 step for each operation.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [ACC_W-1:0] acc_step;

  // Sign-fixed results presented at the commit edge.
  logic [ACC_W-1:0] prod_fix;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign op_code   = mdu_code_e'(op);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    launch    = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        accept = start && !cancel;
        launch = accept && op_is_arith;
        mt_hi  = accept && (op_code == MDU_MTHI);
        mt_lo  = accept && (op_code == MDU_MTLO);
        if (launch) begin
          state_nxt = ITER;
        end
      end
      ITER: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (last_iter) begin
            state_nxt = FIX;
          end
        end
      end
      FIX: begin
        commit    = !cancel;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand magnitudes and result sign flags; a zero divisor keeps the
  // dividend raw so the magnitude math yields lo=all ones, hi=dividend.
  always_comb begin
    op_is_arith = (op_code == MDU_MULT) || (op_code == MDU_MULTU) ||
                  (op_code == MDU_DIV)  || (op_code == MDU_DIVU);
    op_is_div   = (op_code == MDU_DIV)  || (op_code == MDU_DIVU);
    op_signed   = (op_code == MDU_MULT) || (op_code == MDU_DIV);
    use_sign    = op_signed && !(op_is_div && (opB == '0));
    a_neg       = use_sign && opA[WIDTH-1];
    b_neg       = use_sign && opB[WIDTH-1];
    a_mag       = WIDTH'(negate_if(a_neg, NEG_W'(opA)));
    b_mag       = WIDTH'(negate_if(b_neg, NEG_W'(opB)));
  end

  // Single iteration step: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc[ACC_W-1:WIDTH]} + {1'b0, breg & {WIDTH{acc[0]}}};
    div_shift = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, breg};
    div_ge    = ~div_diff[WIDTH];
    if (is_div) begin
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes.
  always_comb begin
    prod_fix = ACC_W'(negate_if(neg_q, NEG_W'(acc)));
    if (is_div) begin
      res_hi = WIDTH'(negate_if(neg_r, NEG_W'(acc[ACC_W-1:WIDTH])));
      res_lo = WIDTH'(negate_if(neg_q, NEG_W'(acc[WIDTH-1:0])));
    end else begin
      res_hi = prod_fix[ACC_W-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Datapath, HI/LO and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      breg   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= commit;
      if (launch) begin
        acc    <= op_is_div ? {WIDTH'(0), a_mag} : {WIDTH'(0), b_mag};
        breg   <= op_is_div ? b_mag : a_mag;
        cnt    <= '0;
        is_div <= op_is_div;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
      end
      if (step) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (mt_hi) begin
        hi <= opA;
      end
      if (mt_lo) begin
        lo <= opA;
      end
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random ops against
// a reference model, and hand sequences for cancel/reset corner cases.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    mdu_code_e   op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t        vt[12];
  exp_t        sb[$];
  int          nvec;
  int          nerr;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .opA    (opA),
    .opB    (opB),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference model using wide native arithmetic.
  task automatic model(input mdu_code_e o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sa, sb_, p, q, r;
    logic        [63:0] up;
    sa  = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    h = '0;
    l = '0;
    case (o)
      MDU_MULT:  begin p = sa * sb_; h = p[63:32]; l = p[31:0]; end
      MDU_MULTU: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
      MDU_DIV: begin
        if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
        else begin q = sa / sb_; r = sa % sb_; l = q[31:0]; h = r[31:0]; end
      end
      MDU_DIVU: begin
        if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
        else begin l = a / b; h = a % b; end
      end
      default: begin h = '0; l = '0; end
    endcase
  endtask

  // Issue one arithmetic op, then check latency, busy span, result and pulse width.
  task automatic run_op(input mdu_code_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    int   lat;
    int   bcnt;
    bit   seen;
    exp_t e;
    e.name = nm;
    e.hi   = eh;
    e.lo   = el;
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    opA   = a;
    opB   = b;
    tick();
    start = 1'b0;
    op    = MDU_NONE;
    lat   = 0;
    bcnt  = 0;
    seen  = 1'b0;
    while (!seen && lat <= 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) bcnt++;
        tick();
        lat++;
      end
    end
    if (!seen) begin
      nvec++;
      nerr++;
      $display("FAIL %s timeout: no done within 40 cycles", nm);
      e = sb.pop_front();
    end else begin
      e = sb.pop_front();
      check({e.name, " latency"}, 64'(lat), 64'd33);
      check({e.name, " busy cycles"}, 64'(bcnt), 64'd33);
      check({e.name, " busy at done"}, 64'(busy), 64'd0);
      check({e.name, " hi"}, 64'(hi), 64'(e.hi));
      check({e.name, " lo"}, 64'(lo), 64'(e.lo));
      exp_hi = e.hi;
      exp_lo = e.lo;
      tick();
      check({e.name, " done one cycle"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    bit          seen;
    logic [31:0] mh;
    logic [31:0] ml;
    mdu_code_e   ro;
    logic [31:0] ra;
    logic [31:0] rb;

    nvec   = 0;
    nerr   = 0;
    clk    = 1'b0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = MDU_NONE;
    opA    = '0;
    opB    = '0;
    cancel = 1'b0;
    exp_hi = '0;
    exp_lo = '0;

    vt[0]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[1]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3]  = '{MDU_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vt[4]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[5]  = '{MDU_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vt[6]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vt[7]  = '{MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vt[8]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vt[9]  = '{MDU_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vt[10] = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vt[11] = '{MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    #12;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       ro = MDU_MULT;
        1:       ro = MDU_MULTU;
        2:       ro = MDU_DIV;
        default: ro = MDU_DIVU;
      endcase
      ra = $urandom();
      rb = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : $urandom();
      model(ro, ra, rb, mh, ml);
      run_op(ro, ra, rb, mh, ml, $sformatf("rand%0d", i));
    end

    // MTHI while busy is ignored; cancel mid-iteration drops the result.
    seen  = 1'b0;
    start = 1'b1;
    op    = MDU_MULTU;
    opA   = 32'd3;
    opB   = 32'd4;
    tick();
    start = 1'b0;
    op    = MDU_NONE;
    for (int c = 1; c < 20; c++) begin
      if (c == 10) begin
        start = 1'b1;
        op    = MDU_MTHI;
        opA   = 32'h1234;
      end
      tick();
      if (c == 10) begin
        start = 1'b0;
        op    = MDU_NONE;
        check("mthi while busy ignored", 64'(hi), 64'(exp_hi));
      end
      if (done) seen = 1'b1;
    end
    check("busy before cancel", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel hi kept", 64'(hi), 64'(exp_hi));
    check("cancel lo kept", 64'(lo), 64'(exp_lo));
    for (int c = 0; c < 40; c++) begin
      if (done) seen = 1'b1;
      tick();
    end
    check("no done after cancel", 64'(seen), 64'd0);
    check("hi after cancel window", 64'(hi), 64'(exp_hi));

    // MTLO while idle takes effect at the next edge without busy.
    start = 1'b1;
    op    = MDU_MTLO;
    opA   = 32'hABCD;
    tick();
    start = 1'b0;
    op    = MDU_NONE;
    exp_lo = 32'hABCD;
    check("mtlo lo", 64'(lo), 64'(exp_lo));
    check("mtlo hi kept", 64'(hi), 64'(exp_hi));
    check("mtlo busy", 64'(busy), 64'd0);
    check("mtlo done", 64'(done), 64'd0);

    // MTHI together with cancel in idle is discarded.
    start  = 1'b1;
    cancel = 1'b1;
    op     = MDU_MTHI;
    opA    = 32'h5555;
    tick();
    start  = 1'b0;
    cancel = 1'b0;
    op     = MDU_NONE;
    check("mthi with cancel discarded", 64'(hi), 64'(exp_hi));

    // Asynchronous reset mid-divide.
    start = 1'b1;
    op    = MDU_DIVU;
    opA   = 32'd100;
    opB   = 32'd7;
    tick();
    start = 1'b0;
    op    = MDU_NONE;
    repeat (14) tick();
    #2;
    reset = 1'b1;
    #1;
    check("async reset hi", 64'(hi), 64'd0);
    check("async reset lo", 64'(lo), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    tick();
    check("post reset busy", 64'(busy), 64'd0);
    run_op(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu after reset");

    // Cancel landing in the FIX cycle suppresses the commit.
    seen  = 1'b0;
    start = 1'b1;
    op    = MDU_MULT;
    opA   = 32'd2;
    opB   = 32'd2;
    tick();
    start = 1'b0;
    op    = MDU_NONE;
    for (int c = 0; c < 32; c++) begin
      if (done) seen = 1'b1;
      tick();
    end
    check("fix cycle busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    if (done) seen = 1'b1;
    check("fix cancel busy", 64'(busy), 64'd0);
    check("fix cancel hi kept", 64'(hi), 64'(exp_hi));
    check("fix cancel lo kept", 64'(lo), 64'(exp_lo));
    repeat (5) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("fix cancel no done", 64'(seen), 64'd0);
    check("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit owning the HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO requests issued from the execute stage, using the mult/div/isUnsigned/toHilo classification produced by the instruction decoder.
- Implements iterative shift-add multiplication and restoring division, followed by a sign-fix cycle.
- Asserts busy so the pipeline can stall MFHI/MFLO and further HI/LO-writing instructions.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request valid; sampled only when busy=0
- op  input  3  MduCodeEnum: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
- opA  input  WIDTH  rs value: multiplicand / dividend / MTHI-MTLO data
- opB  input  WIDTH  rt value: multiplier / divisor
- cancel  input  1  exception flush; aborts an in-flight operation
- busy  output  1  operation in flight; new requests are not accepted
- done  output  1  one-cycle pulse in the cycle HI/LO first show a new mult/div result
- hi  output  WIDTH  HI register (remainder / product upper half)
- lo  output  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset (async, active-high): state IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset mid-operation discards all work immediately.
- States:
  - IDLE: wait for start.
  - ITER: WIDTH cycles of iteration.
  - FIX: one sign-correction/commit cycle.
- IDLE, start=1, op=MTHI/MTLO:
  - hi (or lo) <= opA at that edge; no busy, no done; stay IDLE.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU:
  - Latch operands as magnitudes: the signed ops take absolute values; the unsigned ops take them raw.
  - Latch the result-sign flags: quotient/product negative = sign(A) xor sign(B); remainder sign = sign(A).
  - Go to ITER with counter=0; busy=1 from the next cycle.
- IDLE, start=1, op=NONE: ignored.
- ITER:
  - One radix-2 step per cycle; counter increments.
  - At counter=WIDTH-1 go to FIX.
  - Multiply: WIDTH-bit+1 partial-sum adder with a 2*WIDTH shift register.
  - Divide: restoring; WIDTH+1-bit subtract of divisor from partial remainder, shift in quotient bit.
- FIX:
  - Apply two's-complement negation per the latched flags.
  - Commit the result at the exiting edge: hi/lo update, busy=0, done=1 for exactly that one cycle; return to IDLE.
- Latency: start edge to HI/LO update is WIDTH+1 cycles (33 at default). busy=1 for exactly WIDTH+1 cycles.
- Divide by zero (either signedness): lo = all ones, hi = opA (original, unsigned-raw); same latency; no exception is raised.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (falls out of magnitude math; must not be special-cased incorrectly).
- start while busy=1: ignored, including MTHI/MTLO. The pipeline is responsible for stalling.
- cancel while busy=1:
  - Next state IDLE; busy=0 next cycle; hi/lo unchanged; no done.
  - cancel in the FIX cycle also suppresses the commit.
- cancel with start in the same IDLE cycle: the request is discarded, including MTHI/MTLO.
- cancel while IDLE with no start: no effect.
- hi/lo are registered outputs, stable except at the MTHI/MTLO edge or the commit edge.

Decomposition:
- Shared package entries:
  - enum MduCodeEnum (3-bit) in the Enum include, alongside AluCode/SpecCode.
  - State enum MduStateEnum {IDLE, ITER, FIX}, local to the module.
  - WIDTH default taken from the Parameter package word width.
- Single module; no sub-module.
- The negate helper is an inline function in the package: negate-if(flag, value).

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; exactly one done pulse; busy high 33 cycles.
- MULT 0xFFFFFFFD (-3) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Then DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7/2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, latency still 33.
- Start MULTU 3×4; in cycle 10 issue start MTHI 0x1234 (must be ignored); in cycle 20 assert cancel -> busy=0 next cycle, hi/lo keep prior values, no done. Then MTLO 0xABCD while idle -> lo=0xABCD next edge, busy stays 0.
- Start DIVU 100/7; assert reset in cycle 15 -> hi=lo=0 and busy=0 immediately (asynchronous). After release, DIVU 100/7 -> lo=14, hi=2.
- cancel asserted in the FIX cycle of MULT 2×2 -> hi/lo unchanged, done never asserted.
